// File: rtl/key_schedule_ctrl_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM encoding, S-box and Rcon lookups.
package key_schedule_ctrl_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    typedef logic [AES_KW-1:0] rkey_arr_t [0:AES_NR];

    // Forward AES S-box, element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    // Round constant for expansion round 1..10; zero outside that range.
    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] rnd);
        logic [7:0] v;
        case (rnd)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Key-load handshake, status flags and round-key read port of the key-schedule controller.
interface key_schedule_ctrl_if
    import key_schedule_ctrl_pkg::*;
#(
    parameter int KW = AES_KW
);
    logic [KW-1:0]    keyIn;
    logic             keyValid;
    logic             keyReady;
    logic             busy;
    logic             keysReady;
    logic             donePulse;
    logic             rdEn;
    logic [IDX_W-1:0] rdIdx;
    logic [KW-1:0]    rdKey;
    logic             rdValid;

    modport master (
        output keyIn, keyValid, rdEn, rdIdx,
        input  keyReady, busy, keysReady, donePulse, rdKey, rdValid
    );

    modport slave (
        input  keyIn, keyValid, rdEn, rdIdx,
        output keyReady, busy, keysReady, donePulse, rdKey, rdValid
    );
endinterface

// File: rtl/key_schedule_ctrl_round.sv
// One AES-128 KeyExpansion round: derives round key N from round key N-1 and the round number.
module key_schedule_ctrl_round
    import key_schedule_ctrl_pkg::*;
(
    input  logic [AES_KW-1:0] i_key,
    input  logic [IDX_W-1:0]  i_round,
    output logic [AES_KW-1:0] o_key
);
    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_key[127:96];
    assign w_w1 = i_key[95:64];
    assign w_w2 = i_key[63:32];
    assign w_w3 = i_key[31:0];

    // RotWord then SubWord on the last word, then fold in the round constant.
    assign w_rot  = {w_w3[23:0], w_w3[31:24]};
    assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    assign w_temp = w_sub ^ {rcon(i_round), 24'h000000};

    // Each new word chains off the previous new word.
    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller: one shared expansion round per clock,
// all round keys kept in a local register file behind a registered read port.
module key_schedule_ctrl
    import key_schedule_ctrl_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
)
(
    input logic                clk,
    input logic                rstN,
    key_schedule_ctrl_if.slave bus
);
    localparam logic [IDX_W-1:0] NR_C = IDX_W'(NR);

    state_t           r_state;
    state_t           w_nextState;
    logic [IDX_W-1:0] r_roundCount;
    logic             r_keysReady;
    logic             r_donePulse;
    logic             r_rdValid;
    logic [KW-1:0]    r_rdKey;
    logic [KW-1:0]    r_slot [0:NR];

    logic             w_keyReady;
    logic             w_busy;
    logic             w_accept;
    logic             w_lastRound;
    logic [IDX_W-1:0] w_prevIdx;
    logic [KW-1:0]    w_roundIn;
    logic [KW-1:0]    w_roundOut;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake decode; a key is taken only outside EXPAND.
    always_comb begin
        w_nextState = r_state;
        w_keyReady  = 1'b1;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_lastRound = 1'b0;
        case (r_state)
            ST_IDLE, ST_READY: begin
                w_accept = bus.keyValid;
                if (w_accept) begin
                    w_nextState = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_keyReady  = 1'b0;
                w_busy      = 1'b1;
                w_lastRound = (r_roundCount == NR_C);
                if (w_lastRound) begin
                    w_nextState = ST_READY;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Round counter and completion flags.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_roundCount <= '0;
            r_keysReady  <= 1'b0;
            r_donePulse  <= 1'b0;
        end else begin
            r_donePulse <= 1'b0;
            if (w_accept) begin
                r_roundCount <= 4'd1;
                r_keysReady  <= 1'b0;
            end else if (w_busy) begin
                if (w_lastRound) begin
                    r_roundCount <= '0;
                    r_keysReady  <= 1'b1;
                    r_donePulse  <= 1'b1;
                end else begin
                    r_roundCount <= r_roundCount + 1'b1;
                end
            end
        end
    end

    // Guard keeps the feedback index in range while the counter rests at zero.
    assign w_prevIdx = (r_roundCount == '0) ? '0 : (r_roundCount - 1'b1);
    assign w_roundIn = r_slot[w_prevIdx];

    key_schedule_ctrl_round u_round (
        .i_key   (w_roundIn),
        .i_round (r_roundCount),
        .o_key   (w_roundOut)
    );

    // Round-key register file; not reset, keysReady gates visibility.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_slot[0] <= bus.keyIn;
        end else if (w_busy) begin
            r_slot[r_roundCount] <= w_roundOut;
        end
    end

    // Registered read port; returns pre-edge contents when a new key lands at the same edge.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_rdValid <= 1'b0;
            r_rdKey   <= '0;
        end else if (bus.rdEn) begin
            if (r_keysReady && (bus.rdIdx <= NR_C)) begin
                r_rdKey   <= r_slot[bus.rdIdx];
                r_rdValid <= 1'b1;
            end else begin
                r_rdKey   <= '0;
                r_rdValid <= 1'b0;
            end
        end else begin
            r_rdValid <= 1'b0;
        end
    end

    assign bus.keyReady  = w_keyReady;
    assign bus.busy      = w_busy;
    assign bus.keysReady = r_keysReady;
    assign bus.donePulse = r_donePulse;
    assign bus.rdKey     = r_rdKey;
    assign bus.rdValid   = r_rdValid;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl with a FIPS-197 word-level key-expansion reference model.
module tb_key_schedule_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [7:0]   m_sbox [0:255];
    logic [127:0] m_keys [0:10];

    key_schedule_ctrl_if bus ();

    key_schedule_ctrl dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (v != 0 && gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            end
            m_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 KeyExpansion over 44 words.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.donePulse !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    task automatic read_idx(input logic [3:0] idx, output logic [127:0] key, output logic v);
        bus.rdEn  = 1'b1;
        bus.rdIdx = idx;
        step();
        key = bus.rdKey;
        v   = bus.rdValid;
        bus.rdEn = 1'b0;
    endtask

    task automatic test_reset();
        bus.keyIn = '0; bus.keyValid = 1'b0; bus.rdEn = 1'b0; bus.rdIdx = '0;
        rstN = 1'b0;
        step();
        step();
        total++; if (bus.keyReady !== 1'b1)  begin bad++; $display("FAIL rst_keyReady got %b want 1", bus.keyReady); end
        total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        total++; if (bus.keysReady !== 1'b0) begin bad++; $display("FAIL rst_keysReady got %b want 0", bus.keysReady); end
        total++; if (bus.donePulse !== 1'b0) begin bad++; $display("FAIL rst_donePulse got %b want 0", bus.donePulse); end
        total++; if (bus.rdValid !== 1'b0)   begin bad++; $display("FAIL rst_rdValid got %b want 0", bus.rdValid); end
        total++; if (bus.rdKey !== 128'h0)   begin bad++; $display("FAIL rst_rdKey got %h want 0", bus.rdKey); end
        rstN = 1'b1;
        step();
        total++; if (bus.keyReady !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL post_rst_idle got ready=%b busy=%b want 1/0", bus.keyReady, bus.busy);
        end
    endtask

    task automatic test_fips();
        int n;
        logic [127:0] k;
        logic v;
        model_expand(FIPS_KEY);
        bus.keyIn = FIPS_KEY; bus.keyValid = 1'b1;
        step();
        bus.keyValid = 1'b0; bus.keyIn = rand_key();
        total++; if (bus.busy !== 1'b1 || bus.keyReady !== 1'b0) begin
            bad++; $display("FAIL expand_flags got busy=%b ready=%b want 1/0", bus.busy, bus.keyReady);
        end
        wait_done(n);
        total++; if (n != 10) begin bad++; $display("FAIL fips_latency got %0d want 10", n); end
        total++; if (bus.keysReady !== 1'b1) begin bad++; $display("FAIL fips_keysReady got %b want 1", bus.keysReady); end
        step();
        total++; if (bus.donePulse !== 1'b0 || bus.keysReady !== 1'b1) begin
            bad++; $display("FAIL done_one_cycle got done=%b kr=%b want 0/1", bus.donePulse, bus.keysReady);
        end
        read_idx(4'd0, k, v);
        total++; if (k !== FIPS_KEY || v !== 1'b1) begin bad++; $display("FAIL fips_rk0 got %h v=%b want %h", k, v, FIPS_KEY); end
        read_idx(4'd1, k, v);
        total++; if (k !== FIPS_R1 || v !== 1'b1) begin bad++; $display("FAIL fips_rk1 got %h v=%b want %h", k, v, FIPS_R1); end
        read_idx(4'd10, k, v);
        total++; if (k !== FIPS_R10 || v !== 1'b1) begin bad++; $display("FAIL fips_rk10 got %h v=%b want %h", k, v, FIPS_R10); end
        for (int i = 0; i < 11; i++) begin
            read_idx(4'(i), k, v);
            total++; if (k !== m_keys[i] || v !== 1'b1) begin
                bad++; $display("FAIL fips_model_rk%0d got %h v=%b want %h", i, k, v, m_keys[i]);
            end
        end
        step();
        total++; if (bus.rdValid !== 1'b0 || bus.rdKey !== m_keys[10]) begin
            bad++; $display("FAIL rd_hold got v=%b key=%h want 0/%h", bus.rdValid, bus.rdKey, m_keys[10]);
        end
    endtask

    task automatic test_hold_during_expand();
        int n;
        logic [127:0] k;
        logic v;
        bus.keyIn = FIPS_KEY; bus.keyValid = 1'b1;
        step();
        bus.keyIn = 128'h0;
        wait_done(n);
        total++; if (n != 10) begin bad++; $display("FAIL hold_latency got %0d want 10", n); end
        bus.rdEn = 1'b1; bus.rdIdx = 4'd10;
        step();
        bus.rdEn = 1'b0; bus.keyValid = 1'b0;
        total++; if (bus.rdKey !== FIPS_R10 || bus.rdValid !== 1'b1) begin
            bad++; $display("FAIL same_edge_read got %h v=%b want %h", bus.rdKey, bus.rdValid, FIPS_R10);
        end
        total++; if (bus.keysReady !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL same_edge_accept got kr=%b busy=%b want 0/1", bus.keysReady, bus.busy);
        end
        model_expand(128'h0);
        wait_done(n);
        total++; if (n != 10) begin bad++; $display("FAIL zero_latency got %0d want 10", n); end
        read_idx(4'd10, k, v);
        total++; if (k !== ZERO_R10 || v !== 1'b1) begin bad++; $display("FAIL zero_rk10 got %h v=%b want %h", k, v, ZERO_R10); end
        for (int i = 0; i < 11; i++) begin
            read_idx(4'(i), k, v);
            total++; if (k !== m_keys[i]) begin bad++; $display("FAIL zero_model_rk%0d got %h want %h", i, k, m_keys[i]); end
        end
    endtask

    task automatic test_same_edge_random();
        int n;
        logic [3:0] idx;
        logic [127:0] old_val, k;
        logic v;
        for (int it = 0; it < 3; it++) begin
            idx = 4'($urandom_range(0, 10));
            old_val = m_keys[idx];
            bus.keyIn = rand_key(); bus.keyValid = 1'b1;
            bus.rdEn = 1'b1; bus.rdIdx = idx;
            model_expand(bus.keyIn);
            step();
            bus.keyValid = 1'b0; bus.rdEn = 1'b0;
            total++; if (bus.rdKey !== old_val || bus.rdValid !== 1'b1 || bus.keysReady !== 1'b0) begin
                bad++; $display("FAIL rand_same_edge idx=%0d got %h v=%b kr=%b want %h/1/0", idx, bus.rdKey, bus.rdValid, bus.keysReady, old_val);
            end
            wait_done(n);
            total++; if (n != 10) begin bad++; $display("FAIL rand_latency got %0d want 10", n); end
            idx = 4'($urandom_range(0, 10));
            read_idx(idx, k, v);
            total++; if (k !== m_keys[idx] || v !== 1'b1) begin
                bad++; $display("FAIL rand_read idx=%0d got %h v=%b want %h", idx, k, v, m_keys[idx]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        logic [127:0] k;
        logic v;
        bus.keyIn = rand_key(); bus.keyValid = 1'b1;
        step();
        bus.keyValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        total++; if (bus.keyReady !== 1'b1 || bus.busy !== 1'b0 || bus.keysReady !== 1'b0) begin
            bad++; $display("FAIL mid_rst_state got ready=%b busy=%b kr=%b want 1/0/0", bus.keyReady, bus.busy, bus.keysReady);
        end
        read_idx(4'd0, k, v);
        total++; if (v !== 1'b0 || k !== 128'h0) begin bad++; $display("FAIL mid_rst_read got v=%b key=%h want 0/0", v, k); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.donePulse === 1'b1 || bus.keysReady === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_abandon got done_seen=%b want 0", seen); end
        bus.keyIn = 128'h0; bus.keyValid = 1'b1;
        step();
        bus.keyValid = 1'b0;
        wait_done(n);
        total++; if (n != 10) begin bad++; $display("FAIL reload_latency got %0d want 10", n); end
        read_idx(4'd10, k, v);
        total++; if (k !== ZERO_R10 || v !== 1'b1) begin bad++; $display("FAIL reload_rk10 got %h v=%b want %h", k, v, ZERO_R10); end
        model_expand(128'h0);
    endtask

    task automatic test_bad_idx();
        int n;
        logic [127:0] k;
        logic v;
        for (int i = 11; i < 16; i++) begin
            read_idx(4'd3, k, v);
            read_idx(4'(i), k, v);
            total++; if (v !== 1'b0 || k !== 128'h0) begin bad++; $display("FAIL bad_idx%0d got v=%b key=%h want 0/0", i, v, k); end
        end
        read_idx(4'd5, k, v);
        bus.keyIn = rand_key(); bus.keyValid = 1'b1;
        model_expand(bus.keyIn);
        step();
        bus.keyValid = 1'b0;
        read_idx(4'($urandom_range(0, 10)), k, v);
        total++; if (v !== 1'b0 || k !== 128'h0) begin bad++; $display("FAIL notready_read got v=%b key=%h want 0/0", v, k); end
        wait_done(n);
        total++; if (n != 9) begin bad++; $display("FAIL bad_idx_latency got %0d want 9", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [3:0] idx;
        logic [127:0] k;
        logic v;
        for (int it = 0; it < 4; it++) begin
            bus.keyIn = rand_key(); bus.keyValid = 1'b1;
            model_expand(bus.keyIn);
            step();
            bus.keyValid = 1'b0;
            wait_done(n);
            total++; if (n != 10) begin bad++; $display("FAIL b2b_latency it=%0d got %0d want 10", it, n); end
            for (int r = 0; r < 3; r++) begin
                idx = 4'($urandom_range(0, 10));
                read_idx(idx, k, v);
                total++; if (k !== m_keys[idx] || v !== 1'b1) begin
                    bad++; $display("FAIL b2b_read it=%0d idx=%0d got %h v=%b want %h", it, idx, k, v, m_keys[idx]);
                end
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_hold_during_expand();
        test_same_edge_random();
        test_reset_mid();
        test_bad_idx();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
